// File: rtl/game_pkg.sv
// Shared T-rex game definitions: state encoding and datapath widths used by
// the flow controller, renderer and score display.
package game_pkg;

  localparam int SCORE_W = 14;
  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    RUN   = 2'b01,
    DEAD  = 2'b10,
    CLEAR = 2'b11
  } game_state_t;

endpackage

// File: rtl/game_flow_controller_if.sv
// Frame-level control bundle between the game sequencer and its neighbours.
interface game_flow_controller_if #(
  parameter int SCORE_W = game_pkg::SCORE_W
);
  import game_pkg::*;

  logic                 frame_tick;
  logic                 btn;
  logic                 collided;
  game_state_t          game_state;
  logic                 run_en;
  logic                 clear_pulse;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   hi_score;
  logic [LEVEL_W-1:0]   speed_level;

  modport master (
    output frame_tick, btn, collided,
    input  game_state, run_en, clear_pulse, score, hi_score, speed_level
  );

  modport slave (
    input  frame_tick, btn, collided,
    output game_state, run_en, clear_pulse, score, hi_score, speed_level
  );

endinterface

// File: rtl/game_flow_controller_btn_edge_detect.sv
// Registers a synchronised level button and emits a pulse on its rising edge.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q_reg;

  always_ff @(posedge clk) begin
    if (rst) btn_q_reg <= 1'b0;
    else     btn_q_reg <= btn;
  end

  assign press = btn & ~btn_q_reg;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: INIT/CLEAR/RUN/DEAD flow, score, high score and
// speed-level scheduling for the per-frame datapath.
module game_flow_controller #(
  parameter int SCORE_W          = game_pkg::SCORE_W,
  parameter int SPEED_STEP       = 100,
  parameter int MAX_LEVEL        = 7,
  parameter int DEAD_HOLD_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  game_flow_controller_if.slave bus
);
  import game_pkg::*;

  localparam int STEP_W = $clog2(SPEED_STEP + 1);
  localparam int HOLD_W = $clog2(DEAD_HOLD_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t         state_reg, state_next;
  logic                run_en_reg, run_en_next;
  logic                clear_pulse_reg, clear_pulse_next;
  logic [SCORE_W-1:0]  score_reg, score_next;
  logic [SCORE_W-1:0]  hi_score_reg, hi_score_next;
  logic [LEVEL_W-1:0]  level_reg, level_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                press;

  btn_edge_detect u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= INIT;
      run_en_reg      <= 1'b0;
      clear_pulse_reg <= 1'b0;
      score_reg       <= '0;
      hi_score_reg    <= '0;
      level_reg       <= '0;
      step_reg        <= '0;
      hold_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      run_en_reg      <= run_en_next;
      clear_pulse_reg <= clear_pulse_next;
      score_reg       <= score_next;
      hi_score_reg    <= hi_score_next;
      level_reg       <= level_next;
      step_reg        <= step_next;
      hold_reg        <= hold_next;
    end
  end

  // A press that lands on the tick zeroing the hold counter still sees hold_reg>0.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:  if (press) state_next = CLEAR;
      CLEAR: state_next = RUN;
      RUN:   if (bus.collided) state_next = DEAD;
      DEAD:  if (press && hold_reg == '0) state_next = CLEAR;
    endcase
  end

  always_comb begin
    run_en_next      = (state_next == RUN);
    clear_pulse_next = (state_next == CLEAR);
    score_next       = score_reg;
    hi_score_next    = hi_score_reg;
    level_next       = level_reg;
    step_next        = step_reg;
    hold_next        = hold_reg;

    if (state_next == CLEAR) begin
      score_next = '0;
      level_next = '0;
      step_next  = '0;
    end else if (state_reg == RUN) begin
      if (bus.collided) begin
        hold_next = HOLD_W'(DEAD_HOLD_FRAMES);
        if (score_reg > hi_score_reg) hi_score_next = score_reg;
      end else if (bus.frame_tick) begin
        if (score_reg != SCORE_MAX) score_next = score_reg + 1'b1;
        if (step_reg == STEP_W'(SPEED_STEP - 1)) begin
          step_next = '0;
          if (level_reg != LEVEL_W'(MAX_LEVEL)) level_next = level_reg + 1'b1;
        end else begin
          step_next = step_reg + 1'b1;
        end
      end
    end else if (state_reg == DEAD) begin
      if (bus.frame_tick && hold_reg != '0) hold_next = hold_reg - 1'b1;
    end
  end

  assign bus.game_state  = state_reg;
  assign bus.run_en      = run_en_reg;
  assign bus.clear_pulse = clear_pulse_reg;
  assign bus.score       = score_reg;
  assign bus.hi_score    = hi_score_reg;
  assign bus.speed_level = level_reg;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Top-level game sequencer for the T-rex datapath. It owns the game state (init / run / dead / clear) and accepts a player button for start and restart. It also keeps the running score and high score, and schedules the speed level that the obstacle and scroll logic consume. Sits between the input synchroniser, frame-tick generator, collision detector and all per-frame datapath blocks.

Parameters:
SCORE_W, 14, width of score and high score
SPEED_STEP, 100, frame ticks in RUN per speed-level increment
MAX_LEVEL, 7, saturation value of speed_level (fits 3 bits)
DEAD_HOLD_FRAMES, 60, frame ticks after death before restart is accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
btn  in  1  jump/start button, already synchronised, level
collided  in  1  collision flag from detector, level
game_state  out  2  00 INIT, 01 RUN, 10 DEAD, 11 CLEAR
run_en  out  1  high while game_state==RUN
clear_pulse  out  1  one-cycle clear to obstacle/score datapath
score  out  SCORE_W  current score
hi_score  out  SCORE_W  best score since reset
speed_level  out  3  current difficulty level

Behaviour:
- All outputs registered. An event at cycle N is visible at N+1.
- Reset values: game_state=INIT, run_en=0, clear_pulse=0, score=0, hi_score=0, speed_level=0. Internal step counter, hold counter and btn_q are also 0.
- Reset wins over every other input in the same cycle, including mid-RUN or mid-DEAD.
- press = btn & ~btn_q, where btn_q is btn delayed one cycle. Only rising edges count; a held button never re-triggers.
- INIT: idle, nothing counts. On press -> CLEAR.
- CLEAR: lasts exactly one cycle.
  - clear_pulse=1.
  - score, speed_level and step counter are zeroed.
  - collided and press are ignored.
  - Next state is always RUN.
- RUN:
  - On frame_tick, score += 1, saturating at 2^SCORE_W-1.
  - On frame_tick, step counter += 1. When it reaches SPEED_STEP it wraps to 0, and speed_level += 1, saturating at MAX_LEVEL.
  - collided=1 -> DEAD next cycle. If collided and frame_tick coincide, collision has priority: score, step counter and speed_level are not updated that cycle.
  - press has no effect in RUN; jump is handled elsewhere.
- DEAD entry, in the same edge as the RUN->DEAD transition:
  - hold counter loads DEAD_HOLD_FRAMES.
  - if score > hi_score, hi_score takes the score value. Equal scores do not update.
- DEAD:
  - hold counter decrements on each frame_tick and stops at 0.
  - score and speed_level are frozen; collided is ignored.
  - press with hold counter==0 -> CLEAR.
  - press while hold counter>0 is discarded, not latched.
  - a frame_tick that brings the counter to 0 and a press in the same cycle do not restart; the press must come later.
- No illegal states: game_state is 2 bits and all four encodings are defined.

Decomposition:
- Shared package game_pkg:
  - state encoding constants INIT/RUN/DEAD/CLEAR, reused by renderer and score display.
  - SCORE_W and speed-level width constants.
- One natural sub-module: btn_edge_detect (register plus rising-edge pulse), reusable by the jump controller.
- Score/speed counting stays inline.

Test Plan:
All scenarios use SPEED_STEP=3, DEAD_HOLD_FRAMES=4, SCORE_W=14.
1. Reset and start:
   - Stimulus: rst 2 cycles, then btn rising edge.
   - Required: state INIT; CLEAR for one cycle with clear_pulse=1; then RUN with run_en=1; score=0.
2. Speed ramp:
   - Stimulus: in RUN, 7 frame_ticks.
   - Required: score=7, speed_level=2.
   - Stimulus: continue to 24 ticks.
   - Required: speed_level saturates at 7; score=24.
3. Collision priority:
   - Stimulus: collided and frame_tick in the same cycle at score=5.
   - Required: DEAD next cycle; score stays 5; hi_score=5.
4. Hold window:
   - Stimulus: in DEAD, press after 2 frame_ticks.
   - Required: ignored, stays DEAD.
   - Stimulus: press after the 4th tick (counter=0).
   - Required: CLEAR, score=0, speed_level=0, then RUN; hi_score stays 5.
5. High score tie and held button:
   - Stimulus: second run dies at score=5 while btn held high throughout.
   - Required: hi_score stays 5; no restart until btn goes low then high again.
6. Reset mid-DEAD:
   - Stimulus: rst asserted during hold.
   - Required: INIT, hi_score=0, all outputs at reset values next cycle.
